lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit between the EX stage and the word-addressed data memory (combinational read, word-only write).
//  Handles LB/LH/LW/LBU/LHU and SB/SH/SW: lane selection, sign/zero extension and misalignment detection.
//  Because memory has no byte enables, SB/SH run as a 2-cycle read-modify-write (RMW).
//  The old word is registered between read and write to break the mem_rd->mem_wd path.
//  Sole master of the data memory; stalls the pipeline via req_ready.
// PARAMETERS
//  AW               32  byte-address width on req_addr/mem_a
//  ERR_ON_MISALIGN  1   1: misaligned access flagged, no memory access; 0: low addr bits forced to alignment, access performed
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   EX request present
//  req_ready     out  1   request accepted this cycle when req_valid&req_ready
//  req_we        in   1   1=store, 0=load
//  req_funct3    in   3   RV32I funct3 (size/sign)
//  req_addr      in   AW  byte address
//  req_wdata     in   32  store data (low byte/half used for SB/SH)
//  resp_valid    out  1   one-cycle pulse: access complete
//  resp_rdata    out  32  extended load data (0 for stores/errors)
//  misalign_err  out  1   one-cycle pulse with resp_valid on misaligned/illegal access
//  mem_we        out  1   data memory write enable
//  mem_a         out  AW  data memory byte address (word-aligned, [1:0]=0)
//  mem_wd        out  32  data memory write data
//  mem_rd        in   32  data memory combinational read data
// BEHAVIOUR
//  Reset (async): state=IDLE; resp_valid, misalign_err = 0; resp_rdata, old_q, captured regs = 0.
//  Reset forces mem_we=0 immediately, since it decodes from state/req.
//  Accepted funct3: loads 000,001,010,100,101; stores 000,001,010. Any other code = illegal (same as misaligned).
//  Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
//  FSM states: IDLE, MERGE.
//  IDLE: req_ready=1; mem_a={req_addr[AW-1:2],2'b00}.
//   On accepted request:
//   - error: no mem_we; next cycle resp_valid=1, misalign_err=1, resp_rdata=0.
//     Applies when ERR_ON_MISALIGN=1 or funct3 is illegal.
//   - load: next cycle resp_valid=1, resp_rdata=extend(lane(mem_rd)) (latency 1).
//     Byte lane=addr[1:0], half lane=addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
//   - SW: mem_we=1 and mem_wd=req_wdata in the same cycle; next cycle resp_valid=1 (latency 1).
//   - SB/SH: mem_we=0; latch old_q<=mem_rd plus addr/funct3/wdata; go to MERGE.
//  MERGE: req_ready=0; mem_a=latched addr; mem_we=1.
//   mem_wd = old_q with the addressed byte/half replaced by latched wdata[7:0]/[15:0].
//   Next state IDLE; next cycle resp_valid=1, rdata=0. Sub-word store latency 2, throughput one per 2 cycles.
//  No request is accepted in MERGE. Requests held through MERGE are accepted in the following IDLE cycle.
//  A load right after a sub-word store therefore sees the merged word.
//  resp_valid is high for exactly one cycle per accepted request, never otherwise.
//  Async reset during MERGE: write aborted (mem_we low), memory keeps old word, no resp_valid.
//  Addresses use byte granularity; wrap-around comes only from AW truncation, with no special handling.
// TESTING
//  LB 0x11 / LB 0x13 / LHU 0x12 / LH 0x12 (mem[0x10]=0x87654321): resp_rdata 0x00000043 / 0xFFFFFF87 / 0x00008765 / 0xFFFF8765, each 1 cycle later.
//  SB 0xAA @0x12 on 0x87654321: req_ready=0 one cycle; MERGE mem_we=1, mem_wd=0x87AA4321; resp_valid at cycle 2.
//  SW 0xDEADBEEF @0x20: mem_we=1 in acceptance cycle, mem_a=0x20; resp_valid next cycle, rdata=0.
//  LW @0x22, then SB with funct3=011: each gives misalign_err=resp_valid=1 pulse, rdata=0, mem_we never asserted.
//  rst_n low mid-MERGE (SH pending): mem_we drops at once, memory word unchanged, all outputs 0, state IDLE.
//  SH 0xBEEF @0x30 then LW @0x30 with req_valid held: LW accepted only after MERGE and returns the merged word.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit between EX and a word-only data memory: lane select, sign/zero
// extension, misalignment detection, and a two-cycle read-modify-write for SB/SH.
module lsu_ctrl #(
  parameter int AW              = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          misalign_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  typedef enum logic {IDLE, MERGE} state_t;
  state_t state, state_next;

  logic [31:0]   old_q;
  logic [AW-1:0] addr_q;
  logic          half_q;
  logic [15:0]   wdata_q;

  logic        accept, is_half, is_word, legal, misaligned, err, sub_store;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext, merged;

  assign accept     = (state == IDLE) && req_valid;
  assign is_half    = (req_funct3[1:0] == 2'b01);
  assign is_word    = (req_funct3[1:0] == 2'b10);
  assign legal      = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                             : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
  assign err        = !legal || (misaligned && ERR_ON_MISALIGN);
  assign sub_store  = req_we && !err && !is_word;

  // Lane bits are forced to alignment; only matters when misaligned accesses proceed.
  assign lane    = req_addr[1:0] & {!is_word, !(is_half || is_word)};
  assign ld_byte = mem_rd[{lane, 3'b000} +: 8];
  assign ld_half = mem_rd[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rd;
    case (req_funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = mem_rd;
    endcase
  end

  always_comb begin
    merged = old_q;
    if (half_q) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  // State register plus the registered response and RMW capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      misalign_err <= 1'b0;
      resp_rdata   <= 32'h0;
      old_q        <= 32'h0;
      addr_q       <= '0;
      half_q       <= 1'b0;
      wdata_q      <= 16'h0;
    end else begin
      state        <= state_next;
      resp_valid   <= 1'b0;
      misalign_err <= 1'b0;
      resp_rdata   <= 32'h0;
      if (state == MERGE) begin
        resp_valid <= 1'b1;
      end else if (accept) begin
        if (err) begin
          resp_valid   <= 1'b1;
          misalign_err <= 1'b1;
        end else if (!req_we) begin
          resp_valid <= 1'b1;
          resp_rdata <= load_ext;
        end else if (is_word) begin
          resp_valid <= 1'b1;
        end else begin
          old_q   <= mem_rd;
          addr_q  <= {req_addr[AW-1:2], lane};
          half_q  <= is_half;
          wdata_q <= req_wdata[15:0];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && sub_store) state_next = MERGE;
      MERGE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_we is gated by rst_n so an asserted reset kills a write in flight immediately.
  always_comb begin
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_a     = {req_addr[AW-1:2], 2'b00};
    mem_wd    = req_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        mem_we    = rst_n && accept && req_we && !err && is_word;
      end
      MERGE: begin
        mem_we = rst_n;
        mem_a  = {addr_q[AW-1:2], 2'b00};
        mem_wd = merged;
      end
      default: ;
    endcase
  end

endmodule
